// File: rtl/aes_uart_cmd_ctrl_if.sv
// aes_uart_cmd_ctrl_if: frame, transmit and AES-core signals of the command controller
interface aes_uart_cmd_ctrl_if;
  logic frame_valid;
  logic [143:0] frame_in;
  logic tx_ready;
  logic [143:0] tx_frame;
  logic tx_send;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic aes_ld;
  logic aes_done;
  logic [127:0] aes_text_out;
  logic busy;
  logic [7:0] err_count;
  modport master(
    output frame_valid, frame_in, tx_ready, aes_done, aes_text_out,
    input tx_frame, tx_send, aes_key, aes_text_in, aes_ld, busy, err_count
  );
  modport slave(
    input frame_valid, frame_in, tx_ready, aes_done, aes_text_out,
    output tx_frame, tx_send, aes_key, aes_text_in, aes_ld, busy, err_count
  );
endinterface

// File: rtl/aes_uart_cmd_ctrl.sv
// aes_uart_cmd_ctrl: UART frame command decoder and AES core sequencer
module aes_uart_cmd_ctrl #(
  parameter int FRAME_BYTES = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  aes_uart_cmd_ctrl_if.slave bus
);
  localparam int W = FRAME_BYTES * 8;
  typedef enum logic [2:0] {IDLE, DECODE, AES_START, AES_WAIT, TX_WAIT, TX_SEND} state_t;
  state_t state, state_n;
  logic [W-1:0] frame;
  logic [7:0] cmd, err, cnt;
  logic [127:0] payload, key, pt, result;
  logic [143:0] txf, reply;
  logic reply_en, key_ld, pt_ld, res_ld, err_inc, drop;
  assign cmd = frame[W-1-:8];
  assign payload = frame[W-9:8];
  assign drop = bus.frame_valid && state != IDLE;
  assign bus.tx_frame = txf;
  assign bus.tx_send = state == TX_SEND;
  assign bus.aes_key = key;
  assign bus.aes_text_in = pt;
  assign bus.aes_ld = state == AES_START;
  assign bus.busy = state != IDLE;
  assign bus.err_count = err;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state and the register loads each state requests
  always_comb begin
    state_n = state;
    reply = '0;
    reply_en = 1'b0;
    key_ld = 1'b0;
    pt_ld = 1'b0;
    res_ld = 1'b0;
    err_inc = 1'b0;
    case (state)
      IDLE: state_n = bus.frame_valid ? DECODE : IDLE;
      DECODE: begin
        state_n = TX_WAIT;
        reply_en = 1'b1;
        case (cmd == frame[7:0] ? cmd : 8'h00)
          8'h41: reply = {cmd, "0123456789ABCDEF", cmd};
          8'h42: reply = {cmd, result, cmd};
          8'h61: reply = {cmd, key, cmd};
          8'h62: reply = {cmd, pt, cmd};
          8'h43: begin reply_en = 1'b0; key_ld = 1'b1; state_n = IDLE; end
          8'h44: begin reply_en = 1'b0; pt_ld = 1'b1; state_n = IDLE; end
          8'h45: begin reply_en = 1'b0; state_n = AES_START; end
          8'h46: begin reply_en = 1'b0; pt_ld = 1'b1; state_n = AES_START; end
          default: begin reply = {8'h3F, 128'h0, 8'h3F}; err_inc = 1'b1; end
        endcase
      end
      AES_START: state_n = AES_WAIT;
      AES_WAIT:
        if (cnt != 8'd0 && bus.aes_done) begin
          res_ld = 1'b1;
          reply = {cmd, bus.aes_text_out, cmd};
          reply_en = cmd == 8'h46;
          state_n = cmd == 8'h46 ? TX_WAIT : IDLE;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          reply = {8'h21, 128'h0, 8'h21};
          reply_en = 1'b1;
          err_inc = 1'b1;
          state_n = TX_WAIT;
        end
      TX_WAIT: state_n = bus.tx_ready ? TX_SEND : TX_WAIT;
      TX_SEND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // latched frame, AES operands, result, reply frame, wait counter and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      key <= '0;
      pt <= '0;
      result <= '0;
      txf <= '0;
      cnt <= '0;
      err <= '0;
    end else begin
      if (state == IDLE && bus.frame_valid) frame <= bus.frame_in;
      if (key_ld) key <= payload;
      if (pt_ld) pt <= payload;
      if (res_ld) result <= bus.aes_text_out;
      if (reply_en) txf <= reply;
      cnt <= state == AES_WAIT ? cnt + 8'd1 : 8'd0;
      if ((err_inc || drop) && err != 8'hFF) err <= err + 8'd1;
    end
  end
endmodule

// File: tb/tb_aes_uart_cmd_ctrl.sv
// tb_aes_uart_cmd_ctrl: command-level model and directed vectors for aes_uart_cmd_ctrl
module tb_aes_uart_cmd_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  aes_uart_cmd_ctrl_if bus();
  aes_uart_cmd_ctrl dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] HEX = 128'h30313233343536373839414243444546;
  localparam int AES_LAT = 3;

  int total = 0, bad = 0;
  int n_send = 0, n_ld = 0;
  logic [143:0] exp_q[$];
  logic [143:0] last_tx = '0;
  logic [127:0] m_key = '0, m_pt = '0, m_res = '0;
  int m_err = 0;
  bit aes_stuck = 1'b0;
  int aes_cnt = 0;
  logic [127:0] aes_res = '0;

  // stand-in AES core: known-answer vector for K0/P0, an arbitrary mix otherwise
  function automatic logic [127:0] aes_fn(input logic [127:0] k, input logic [127:0] p);
    return (k == K0 && p == P0) ? C0 : (k ^ {p[63:0], p[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696);
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic err_up();
    if (m_err < 255) m_err++;
  endtask

  // expected effect of one accepted frame on registers, error count and reply stream
  task automatic model(input logic [7:0] c, input logic [127:0] p, input logic [7:0] cc);
    logic known;
    known = c inside {8'h41, 8'h42, 8'h61, 8'h62, 8'h43, 8'h44, 8'h45, 8'h46};
    if (c != cc || !known) begin
      exp_q.push_back({8'h3F, 128'h0, 8'h3F});
      err_up();
    end else if (c == 8'h41) exp_q.push_back({c, "0123456789ABCDEF", c});
    else if (c == 8'h42) exp_q.push_back({c, m_res, c});
    else if (c == 8'h61) exp_q.push_back({c, m_key, c});
    else if (c == 8'h62) exp_q.push_back({c, m_pt, c});
    else if (c == 8'h43) m_key = p;
    else if (c == 8'h44) m_pt = p;
    else begin
      if (c == 8'h46) m_pt = p;
      if (aes_stuck) begin
        exp_q.push_back({8'h21, 128'h0, 8'h21});
        err_up();
      end else begin
        m_res = aes_fn(m_key, m_pt);
        if (c == 8'h46) exp_q.push_back({c, m_res, c});
      end
    end
  endtask

  task automatic pulse(input logic [143:0] f, input int n);
    @(negedge clk);
    bus.frame_in = f;
    bus.frame_valid = 1'b1;
    repeat (n) @(negedge clk);
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (bus.busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", 144'(bus.busy), 144'(0));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_key"}, 144'(bus.aes_key), 144'(m_key));
    chk({tag, "_text_in"}, 144'(bus.aes_text_in), 144'(m_pt));
    chk({tag, "_err"}, 144'(bus.err_count), 144'(m_err));
    chk({tag, "_pending"}, 144'(exp_q.size()), 144'(0));
  endtask

  task automatic cmd(input string tag, input logic [7:0] c, input logic [127:0] p, input logic [7:0] cc);
    model(c, p, cc);
    pulse({c, p, cc}, 1);
    wait_idle();
    check_regs(tag);
  endtask

  // scoreboard: every transmitted frame must match the next expected reply
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.aes_ld) n_ld++;
      if (bus.tx_send) begin
        n_send++;
        last_tx = bus.tx_frame;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx_send: got %h want none", bus.tx_frame);
        end else chk("tx_frame", bus.tx_frame, exp_q.pop_front());
      end
    end
  end

  // AES responder: keeps a stale done for the first wait cycle, then answers after AES_LAT
  always @(negedge clk) begin
    if (reset || aes_stuck) begin
      aes_cnt = 0;
      bus.aes_done = 1'b0;
      if (reset) bus.aes_text_out = '0;
    end else if (bus.aes_ld) begin
      aes_cnt = AES_LAT + 1;
      aes_res = aes_fn(bus.aes_key, bus.aes_text_in);
    end else if (aes_cnt > 0) begin
      aes_cnt--;
      if (aes_cnt == 0) begin
        bus.aes_text_out = aes_res;
        bus.aes_done = 1'b1;
      end else if (aes_cnt < AES_LAT) bus.aes_done = 1'b0;
    end
  end

  initial begin
    int k, s0, l0;
    bus.frame_valid = 1'b0;
    bus.frame_in = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_frame", bus.tx_frame, 144'(0));
    chk("rst_tx_send", 144'(bus.tx_send), 144'(0));
    chk("rst_aes_ld", 144'(bus.aes_ld), 144'(0));
    chk("rst_busy", 144'(bus.busy), 144'(0));
    reset = 1'b0;
    check_regs("rst");

    model(8'h41, 128'h0, 8'h41);
    pulse({8'h41, 128'h0, 8'h41}, 1);
    k = 1;
    while (!bus.tx_send && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("a_latency", 144'(k), 144'(3));
    chk("a_payload", 144'(bus.tx_frame[135:8]), 144'(HEX));
    @(negedge clk);
    chk("a_busy_low", 144'(bus.busy), 144'(0));
    check_regs("a");

    cmd("b0", 8'h42, 128'h0, 8'h42);
    chk("b0_result_zero", 144'(last_tx[135:8]), 144'(0));

    cmd("c", 8'h43, K0, 8'h43);
    chk("c_key_lit", 144'(bus.aes_key), 144'(K0));
    l0 = n_ld;
    cmd("f", 8'h46, P0, 8'h46);
    chk("f_ld_pulses", 144'(n_ld - l0), 144'(1));
    chk("f_frame_lit", last_tx, {8'h46, C0, 8'h46});
    cmd("b1", 8'h42, 128'h0, 8'h42);
    chk("b1_lit", 144'(last_tx[135:8]), 144'(C0));

    cmd("f2", 8'h46, P1, 8'h46);
    cmd("rd_key", 8'h61, 128'h0, 8'h61);
    cmd("d", 8'h44, P0, 8'h44);
    cmd("rd_pt", 8'h62, 128'h0, 8'h62);
    cmd("e", 8'h45, 128'h0, 8'h45);
    cmd("b2", 8'h42, 128'h0, 8'h42);

    cmd("nak_copy", 8'h43, P1, 8'h44);
    chk("nak_lit", last_tx, {8'h3F, 128'h0, 8'h3F});
    chk("nak_err_lit", 144'(bus.err_count), 144'(1));
    cmd("nak_z", 8'h5A, P1, 8'h5A);

    aes_stuck = 1'b1;
    model(8'h45, 128'h0, 8'h45);
    pulse({8'h45, 128'h0, 8'h45}, 1);
    k = 1;
    while (!bus.tx_send && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 144'(k), 144'(68));
    chk("timeout_lit", bus.tx_frame, {8'h21, 128'h0, 8'h21});
    wait_idle();
    check_regs("timeout");
    aes_stuck = 1'b0;
    cmd("b3", 8'h42, 128'h0, 8'h42);

    bus.tx_ready = 1'b0;
    s0 = n_send;
    model(8'h41, 128'h0, 8'h41);
    pulse({8'h41, 128'h0, 8'h41}, 1);
    repeat (4) @(negedge clk);
    err_up();
    pulse({8'h42, 128'h0, 8'h42}, 1);
    for (int i = 0; i < 20; i++) begin
      chk("hold_frame", bus.tx_frame, {8'h41, HEX, 8'h41});
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    wait_idle();
    chk("hold_one_send", 144'(n_send - s0), 144'(1));
    check_regs("hold");

    model(8'h5A, 128'h0, 8'h59);
    pulse({8'h5A, 128'h0, 8'h59}, 2);
    wait_idle();
    check_regs("coincide");
    model(8'h41, 128'h0, 8'h41);
    err_up();
    pulse({8'h41, 128'h0, 8'h41}, 2);
    wait_idle();
    check_regs("drop_decode");

    bus.tx_ready = 1'b0;
    model(8'h00, 128'h0, 8'h01);
    pulse({8'h00, 128'h0, 8'h01}, 1);
    for (int i = 0; i < 300; i++) begin
      err_up();
      pulse({8'h41, 128'h0, 8'h41}, 1);
    end
    chk("sat_lit", 144'(bus.err_count), 144'(255));
    bus.tx_ready = 1'b1;
    wait_idle();
    check_regs("sat");

    aes_stuck = 1'b1;
    s0 = n_send;
    pulse({8'h45, 128'h0, 8'h45}, 1);
    repeat (10) @(negedge clk);
    l0 = n_ld;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_frame", bus.tx_frame, 144'(0));
    chk("mid_rst_busy", 144'(bus.busy), 144'(0));
    chk("mid_rst_send_ld", 144'({bus.tx_send, bus.aes_ld}), 144'(0));
    m_key = '0;
    m_pt = '0;
    m_res = '0;
    m_err = 0;
    exp_q.delete();
    check_regs("mid_rst");
    reset = 1'b0;
    aes_stuck = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_no_send", 144'(n_send - s0), 144'(0));
    chk("post_rst_no_ld", 144'(n_ld - l0), 144'(0));
    cmd("post_rst_b", 8'h42, 128'h0, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
